// File: rtl/ace_pkg.sv
// Shared ACE snoop types: AC snoop codes, CR response bit positions, line state
// encoding and the default request/response channel structs.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 32;
  localparam int unsigned AceDataWidth = 64;

  typedef enum logic [3:0] {
    AcReadOnce           = 4'b0000,
    AcReadShared         = 4'b0001,
    AcReadClean          = 4'b0010,
    AcReadNotSharedDirty = 4'b0011,
    AcReadUnique         = 4'b0111,
    AcCleanShared        = 4'b1000,
    AcCleanInvalid       = 4'b1001,
    AcMakeInvalid        = 4'b1101
  } acsnoop_t;

  typedef logic [4:0] crresp_t;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef struct packed {
    logic shared;
    logic dirty;
    logic valid;
  } line_state_t;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    logic [3:0]              snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  // Error is never signalled by this responder, so it is tied low here.
  function automatic crresp_t make_crresp(input logic was_unique, input logic is_shared,
                                          input logic pass_dirty, input logic data_xfer);
    crresp_t r;
    r                 = '0;
    r[CrWasUnique]    = was_unique;
    r[CrIsShared]     = is_shared;
    r[CrPassDirty]    = pass_dirty;
    r[CrError]        = 1'b0;
    r[CrDataTransfer] = data_xfer;
    return r;
  endfunction

endpackage

// File: rtl/ace_snoop_resp_lut.sv
// Combinational snoop decision table: maps snoop type and looked-up line state
// to the CR response, the next line state and whether a state write is needed.
module ace_snoop_resp_lut
  import ace_pkg::*;
(
  input  logic [3:0]  acsnoop,
  input  logic        hit,
  input  line_state_t state,
  output crresp_t     crresp,
  output line_state_t new_state,
  output logic        do_upd,
  output logic        illegal
);

  logic        dt, is, pd, legal;
  line_state_t ns;

  // Decode per-snoop behaviour; misses and unknown codes collapse to an empty response.
  always_comb begin
    dt        = 1'b0;
    is        = 1'b0;
    pd        = 1'b0;
    legal     = 1'b1;
    ns        = state;
    crresp    = '0;
    new_state = state;
    do_upd    = 1'b0;

    case (acsnoop)
      AcReadOnce: begin
        dt = 1'b1;
        is = 1'b1;
      end
      AcReadShared, AcReadClean, AcReadNotSharedDirty: begin
        dt = 1'b1;
        is = 1'b1;
        pd = state.dirty;
        ns = '{shared: 1'b1, dirty: 1'b0, valid: 1'b1};
      end
      AcReadUnique: begin
        dt = 1'b1;
        pd = state.dirty;
        ns = '0;
      end
      AcCleanInvalid: begin
        dt = state.dirty;
        pd = state.dirty;
        ns = '0;
      end
      AcCleanShared: begin
        dt = state.dirty;
        is = 1'b1;
        pd = state.dirty;
        ns = '{shared: state.shared, dirty: 1'b0, valid: 1'b1};
      end
      AcMakeInvalid: begin
        ns = '0;
      end
      default: legal = 1'b0;
    endcase

    illegal = ~legal;

    if (legal && hit) begin
      crresp    = make_crresp(~state.shared, is, pd, dt);
      new_state = ns;
      do_upd    = (ns != state);
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop slave: accepts one AC request at a time, looks up the line, returns
// CR, streams the line on CD when required and writes back the new line state.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned BeatsPerLine = 4,
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  snoop_req_t                      snoop_req_i,
  output snoop_resp_t                     snoop_resp_o,
  output logic                            lookup_req_o,
  output logic [AddrWidth-1:0]            lookup_addr_o,
  input  logic                            lookup_gnt_i,
  input  logic                            lookup_hit_i,
  input  logic [2:0]                      lookup_state_i,
  output logic                            data_req_o,
  output logic [$clog2(BeatsPerLine)-1:0] data_beat_o,
  input  logic [DataWidth-1:0]            data_rdata_i,
  output logic                            upd_valid_o,
  output logic [AddrWidth-1:0]            upd_addr_o,
  output logic [2:0]                      upd_state_o,
  output logic                            illegal_o
);

  localparam int unsigned BeatW        = $clog2(BeatsPerLine);
  localparam int unsigned OffW         = $clog2(DataWidth / 8);
  localparam int unsigned BytesPerLine = (DataWidth / 8) * BeatsPerLine;
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(BytesPerLine - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCr,
    StDataReq,
    StDataCap,
    StDataSend,
    StUpd
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  crresp_t                cr_q, cr_d;
  line_state_t            new_state_q, new_state_d;
  logic                   do_upd_q, do_upd_d;
  logic                   illegal_q, illegal_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic [BeatW-1:0]       cnt_q, cnt_d;
  logic [DataWidth-1:0]   cd_data_q, cd_data_d;
  logic                   ac_ready_q;

  crresp_t                lut_cr;
  line_state_t            lut_new_state;
  logic                   lut_do_upd;
  logic                   lut_illegal;
  logic                   last_beat;
  logic [AddrWidth-1:0]   line_addr;

  ace_snoop_resp_lut u_lut (
    .acsnoop   (snoop_q),
    .hit       (lookup_hit_i),
    .state     (line_state_t'(lookup_state_i)),
    .crresp    (lut_cr),
    .new_state (lut_new_state),
    .do_upd    (lut_do_upd),
    .illegal   (lut_illegal)
  );

  assign last_beat     = (cnt_q == BeatW'(BeatsPerLine - 1));
  assign line_addr     = addr_q & ~OffMask;
  assign lookup_addr_o = line_addr;
  assign upd_addr_o    = line_addr;
  assign upd_state_o   = new_state_q;
  assign data_beat_o   = beat_q;
  assign illegal_o     = illegal_q;

  // Next-state logic and channel outputs for the snoop FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    snoop_d      = snoop_q;
    cr_d         = cr_q;
    new_state_d  = new_state_q;
    do_upd_d     = do_upd_q;
    illegal_d    = 1'b0;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    cd_data_d    = cd_data_q;
    lookup_req_o = 1'b0;
    data_req_o   = 1'b0;
    upd_valid_o  = 1'b0;

    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready_q;
    snoop_resp_o.cr_resp  = cr_q;
    snoop_resp_o.cd.data  = cd_data_q;

    case (state_q)
      StIdle: begin
        if (snoop_req_i.ac_valid && ac_ready_q) begin
          addr_d  = AddrWidth'(snoop_req_i.ac.addr);
          snoop_d = snoop_req_i.ac.snoop;
          state_d = StLookup;
        end
      end
      StLookup: begin
        lookup_req_o = 1'b1;
        if (lookup_gnt_i) begin
          cr_d        = lut_cr;
          new_state_d = lut_new_state;
          do_upd_d    = lut_do_upd;
          // Registered so the pulse lands on the first CR cycle only.
          illegal_d   = lut_illegal;
          beat_d      = addr_q[OffW +: BeatW];
          cnt_d       = '0;
          state_d     = StCr;
        end
      end
      StCr: begin
        snoop_resp_o.cr_valid = 1'b1;
        if (snoop_req_i.cr_ready) begin
          if (cr_q[CrDataTransfer]) begin
            state_d = StDataReq;
          end else if (do_upd_q) begin
            state_d = StUpd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDataReq: begin
        data_req_o = 1'b1;
        state_d    = StDataCap;
      end
      StDataCap: begin
        // Read data arrives one cycle after the request; hold it for the CD stall.
        cd_data_d = data_rdata_i;
        state_d   = StDataSend;
      end
      StDataSend: begin
        snoop_resp_o.cd_valid = 1'b1;
        snoop_resp_o.cd.last  = last_beat;
        if (snoop_req_i.cd_ready) begin
          beat_d = beat_q + BeatW'(1);
          cnt_d  = cnt_q + BeatW'(1);
          if (!last_beat) begin
            state_d = StDataReq;
          end else if (do_upd_q) begin
            state_d = StUpd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StUpd: begin
        upd_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any snoop in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      snoop_q     <= '0;
      cr_q        <= '0;
      new_state_q <= '0;
      do_upd_q    <= 1'b0;
      illegal_q   <= 1'b0;
      beat_q      <= '0;
      cnt_q       <= '0;
      cd_data_q   <= '0;
      ac_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      cr_q        <= cr_d;
      new_state_q <= new_state_d;
      do_upd_q    <= do_upd_d;
      illegal_q   <= illegal_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      cd_data_q   <= cd_data_d;
      ac_ready_q  <= (state_d == StIdle);
    end
  end

endmodule
